// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: drives PC enable/load, reads instruction memory,
// and hands each word to the decoder. Optional interrupt entry under FETCH_IRQ_EN.
module fetch_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter logic [15:0] IRQ_VECTOR  = 16'h0004
) (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic [15:0] I_pc,
  output logic        O_pc_enable,
  output logic        O_pc_write,
  output logic [15:0] O_pc_in,
  output logic        O_mem_req,
  output logic [15:0] O_mem_addr,
  input  logic        I_mem_ready,
  input  logic [15:0] I_mem_data,
  output logic [15:0] O_ir,
  output logic        O_ir_valid,
  input  logic        I_ir_ack,
  input  logic        I_branch_valid,
  input  logic [15:0] I_branch_target,
  input  logic        I_halt,
  output logic        O_halted,
`ifdef FETCH_IRQ_EN
  input  logic        I_irq,
  output logic        O_irq_ack,
  output logic [15:0] O_epc,
`endif
  output logic        O_fetch_err
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_ISSUE,
    S_HALT
  } state_t;

  localparam int unsigned CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  state_t        state, state_next;
  logic [CW-1:0] tmo_cnt;
  logic          timeout_hit;
  logic          issue_ack;
  logic          branch_take;
  logic          irq_take;
  logic [15:0]   branch_pc;

  assign O_mem_addr  = I_pc;
  assign branch_pc   = I_branch_target & 16'hFFFE;
  assign issue_ack   = (state == S_ISSUE) && I_ir_ack;
  assign branch_take = issue_ack && I_branch_valid;
  // A ready response on the last allowed cycle still wins over the timeout.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (state == S_FETCH) && !I_mem_ready &&
                       (tmo_cnt == CW'(MEM_TIMEOUT - 1));

`ifdef FETCH_IRQ_EN
  assign irq_take = I_irq && (issue_ack || ((state == S_HALT) && !O_fetch_err));
`else
  assign irq_take = 1'b0;
`endif

  always_ff @(posedge I_clk) begin
    if (I_reset) state <= S_FETCH;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: begin
        if (I_mem_ready)      state_next = S_ISSUE;
        else if (timeout_hit) state_next = S_HALT;
      end
      S_ISSUE: begin
        if (I_ir_ack) begin
          if (irq_take)    state_next = S_FETCH;
          else if (I_halt) state_next = S_HALT;
          else             state_next = S_FETCH;
        end
      end
      S_HALT: begin
        if (irq_take) state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  always_comb begin
    O_pc_enable = 1'b0;
    O_pc_write  = 1'b0;
    O_pc_in     = '0;
    O_mem_req   = (state == S_FETCH);
    O_halted    = (state == S_HALT);
`ifdef FETCH_IRQ_EN
    O_irq_ack   = 1'b0;
`endif
    if ((state == S_FETCH) && I_mem_ready) begin
      O_pc_enable = 1'b1;
    end else if (irq_take) begin
      O_pc_enable = 1'b1;
      O_pc_write  = 1'b1;
      O_pc_in     = IRQ_VECTOR;
`ifdef FETCH_IRQ_EN
      O_irq_ack   = 1'b1;
`endif
    end else if (branch_take) begin
      O_pc_enable = 1'b1;
      O_pc_write  = 1'b1;
      O_pc_in     = branch_pc;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      tmo_cnt     <= '0;
      O_ir        <= '0;
      O_ir_valid  <= 1'b0;
      O_fetch_err <= 1'b0;
    end else begin
      if ((state == S_FETCH) && !I_mem_ready) tmo_cnt <= tmo_cnt + 1'b1;
      else                                    tmo_cnt <= '0;
      if ((state == S_FETCH) && I_mem_ready) begin
        O_ir       <= I_mem_data;
        O_ir_valid <= 1'b1;
      end else if (issue_ack) begin
        O_ir_valid <= 1'b0;
      end
      if (timeout_hit) O_fetch_err <= 1'b1;
    end
  end

`ifdef FETCH_IRQ_EN
  always_ff @(posedge I_clk) begin
    if (I_reset)       O_epc <= '0;
    else if (irq_take) O_epc <= branch_take ? branch_pc : I_pc;
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: models the PC register and instruction memory,
// runs a vector table plus hand sequences for timeout, halt, reset and IRQ.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        I_reset = 1'b1;
  logic [15:0] pc_model;
  logic        O_pc_enable, O_pc_write;
  logic [15:0] O_pc_in;
  logic        O_mem_req;
  logic [15:0] O_mem_addr;
  logic        I_mem_ready = 1'b0;
  logic [15:0] I_mem_data = '0;
  logic [15:0] O_ir;
  logic        O_ir_valid;
  logic        I_ir_ack = 1'b0;
  logic        I_branch_valid = 1'b0;
  logic [15:0] I_branch_target = '0;
  logic        I_halt = 1'b0;
  logic        O_halted;
  logic        O_fetch_err;
`ifdef FETCH_IRQ_EN
  logic        I_irq = 1'b0;
  logic        O_irq_ack;
  logic [15:0] O_epc;
`endif

  always #5 clk = ~clk;

  // PC register the sequencer controls
  always @(posedge clk) begin
    if (I_reset)          pc_model <= 16'h0000;
    else if (O_pc_enable) pc_model <= O_pc_write ? O_pc_in : pc_model + 16'd2;
  end

  fetch_sequencer #(
    .MEM_TIMEOUT(4),
    .IRQ_VECTOR (16'h0004)
  ) dut (
    .I_clk          (clk),
    .I_reset        (I_reset),
    .I_pc           (pc_model),
    .O_pc_enable    (O_pc_enable),
    .O_pc_write     (O_pc_write),
    .O_pc_in        (O_pc_in),
    .O_mem_req      (O_mem_req),
    .O_mem_addr     (O_mem_addr),
    .I_mem_ready    (I_mem_ready),
    .I_mem_data     (I_mem_data),
    .O_ir           (O_ir),
    .O_ir_valid     (O_ir_valid),
    .I_ir_ack       (I_ir_ack),
    .I_branch_valid (I_branch_valid),
    .I_branch_target(I_branch_target),
    .I_halt         (I_halt),
    .O_halted       (O_halted),
`ifdef FETCH_IRQ_EN
    .I_irq          (I_irq),
    .O_irq_ack      (O_irq_ack),
    .O_epc          (O_epc),
`endif
    .O_fetch_err    (O_fetch_err)
  );

  typedef struct {
    logic [15:0] data;
    int unsigned ready_delay;
    int unsigned ack_delay;
    logic        branch;
    logic [15:0] target;
  } vec_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;

  vec_t        vecs[6];
  exp_t        sb[$];
  exp_t        e;
  logic [15:0] exp_addr;
  logic [15:0] exp_in;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive();
    I_reset = 1'b1;
    drive();
    I_reset = 1'b0;
    sample();
  endtask

  // From a drive point in S_FETCH: one ready cycle, then sample the issue cycle.
  task automatic do_fetch(input logic [15:0] data);
    I_mem_ready = 1'b1;
    I_mem_data  = data;
    sample();
    check("fetch_pc_en", O_pc_enable, 1'b1);
    drive();
    I_mem_ready = 1'b0;
    sample();
    check("fetch_ir", O_ir, data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{16'h1111, 0, 0, 1'b0, 16'h0000};
    vecs[1] = '{16'h2222, 1, 0, 1'b0, 16'h0000};
    vecs[2] = '{16'h3333, 0, 0, 1'b1, 16'h0101};
    vecs[3] = '{16'h4444, 2, 5, 1'b1, 16'hFFFF};
    vecs[4] = '{16'h5555, 0, 1, 1'b0, 16'h0000};
    vecs[5] = '{16'h6666, 0, 0, 1'b0, 16'h0000};

    drive();
    sample();
    check("rst_ir_valid", O_ir_valid, 1'b0);
    check("rst_ir", O_ir, 16'h0000);
    check("rst_err", O_fetch_err, 1'b0);
    check("rst_halted", O_halted, 1'b0);
    check("rst_pc_en", O_pc_enable, 1'b0);
    check("rst_mem_req", O_mem_req, 1'b1);
    drive();
    I_reset  = 1'b0;
    exp_addr = 16'h0000;

    for (int i = 0; i < 6; i++) begin
      for (int unsigned d = 0; d < vecs[i].ready_delay; d++) begin
        sample();
        check("wait_mem_req", O_mem_req, 1'b1);
        check("wait_pc_en", O_pc_enable, 1'b0);
        drive();
      end
      I_mem_ready = 1'b1;
      I_mem_data  = vecs[i].data;
      sample();
      check("mem_addr", O_mem_addr, exp_addr);
      check("fetch_pc_en", O_pc_enable, 1'b1);
      check("fetch_pc_wr", O_pc_write, 1'b0);
      check("fetch_pc_in", O_pc_in, 16'h0000);
      sb.push_back('{exp_addr, vecs[i].data});
      exp_addr = exp_addr + 16'd2;
      drive();
      I_mem_ready     = 1'b0;
      I_mem_data      = '0;
      I_branch_valid  = 1'b1;
      I_branch_target = 16'hBEEF;
      I_halt          = 1'b1;
      sample();
      check("ir_valid", O_ir_valid, 1'b1);
      check("issue_mem_req", O_mem_req, 1'b0);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty: got no entry, expected one");
        e = '{16'h0000, 16'h0000};
      end else begin
        e = sb.pop_front();
      end
      check("ir_data", O_ir, e.data);
      check("issue_pc", pc_model, e.addr + 16'd2);
      for (int unsigned d = 0; d < vecs[i].ack_delay; d++) begin
        drive();
        sample();
        check("hold_ir", O_ir, e.data);
        check("hold_valid", O_ir_valid, 1'b1);
        check("hold_pc_en", O_pc_enable, 1'b0);
      end
      drive();
      I_ir_ack        = 1'b1;
      I_branch_valid  = vecs[i].branch;
      I_branch_target = vecs[i].target;
      I_halt          = 1'b0;
      sample();
      exp_in = vecs[i].branch ? (vecs[i].target & 16'hFFFE) : 16'h0000;
      check("ack_pc_en", O_pc_enable, vecs[i].branch);
      check("ack_pc_wr", O_pc_write, vecs[i].branch);
      check("ack_pc_in", O_pc_in, exp_in);
      if (vecs[i].branch) exp_addr = vecs[i].target & 16'hFFFE;
      drive();
      I_ir_ack        = 1'b0;
      I_branch_valid  = 1'b0;
      I_branch_target = '0;
    end
    check("sb_drained", 16'(sb.size()), 16'h0000);

    // Timeout after four unanswered fetch cycles
    for (int c = 0; c < 4; c++) begin
      sample();
      check("tmo_not_halted", O_halted, 1'b0);
      check("tmo_mem_req", O_mem_req, 1'b1);
      drive();
    end
    sample();
    check("tmo_err", O_fetch_err, 1'b1);
    check("tmo_halted", O_halted, 1'b1);
    check("tmo_mem_req_off", O_mem_req, 1'b0);
    for (int c = 0; c < 3; c++) begin
      drive();
      sample();
      check("tmo_hold_halt", O_halted, 1'b1);
      check("tmo_hold_pc_en", O_pc_enable, 1'b0);
    end
    check("tmo_pc", pc_model, 16'h0002);

    // Ready on the last allowed cycle: normal capture, then halt with branch
    do_reset();
    check("rst2_err", O_fetch_err, 1'b0);
    check("rst2_addr", O_mem_addr, 16'h0000);
    for (int c = 0; c < 2; c++) begin
      drive();
      sample();
      check("late_not_halted", O_halted, 1'b0);
    end
    drive();
    do_fetch(16'h7777);
    check("late_err", O_fetch_err, 1'b0);
    check("late_valid", O_ir_valid, 1'b1);
    check("late_halted", O_halted, 1'b0);
    drive();
    I_ir_ack        = 1'b1;
    I_halt          = 1'b1;
    I_branch_valid  = 1'b1;
    I_branch_target = 16'h0041;
    sample();
    check("halt_br_pc_en", O_pc_enable, 1'b1);
    check("halt_br_pc_wr", O_pc_write, 1'b1);
    check("halt_br_pc_in", O_pc_in, 16'h0040);
    drive();
    I_ir_ack       = 1'b0;
    I_halt         = 1'b0;
    I_branch_valid = 1'b0;
    sample();
    check("halt_halted", O_halted, 1'b1);
    check("halt_mem_req", O_mem_req, 1'b0);
    check("halt_ir_valid", O_ir_valid, 1'b0);
    for (int c = 0; c < 3; c++) begin
      drive();
      sample();
      check("halt_hold", O_halted, 1'b1);
      check("halt_pc_en", O_pc_enable, 1'b0);
    end
    check("halt_pc", pc_model, 16'h0040);

    // Reset while an instruction waits for ack
    do_reset();
    check("rst3_halted", O_halted, 1'b0);
    drive();
    do_fetch(16'h8888);
    check("mid_valid", O_ir_valid, 1'b1);
    do_reset();
    check("mid_rst_valid", O_ir_valid, 1'b0);
    check("mid_rst_ir", O_ir, 16'h0000);
    check("mid_rst_addr", O_mem_addr, 16'h0000);
    check("mid_rst_req", O_mem_req, 1'b1);

`ifdef FETCH_IRQ_EN
    drive();
    do_fetch(16'h9000);
    drive();
    I_ir_ack        = 1'b1;
    I_branch_valid  = 1'b1;
    I_branch_target = 16'h0010;
    drive();
    I_ir_ack       = 1'b0;
    I_branch_valid = 1'b0;
    do_fetch(16'h9001);
    check("irq_issue_pc", pc_model, 16'h0012);
    drive();
    I_ir_ack = 1'b1;
    I_halt   = 1'b1;
    I_irq    = 1'b1;
    sample();
    check("irq_ack", O_irq_ack, 1'b1);
    check("irq_pc_wr", O_pc_write, 1'b1);
    check("irq_pc_in", O_pc_in, 16'h0004);
    drive();
    I_ir_ack = 1'b0;
    I_halt   = 1'b0;
    I_irq    = 1'b0;
    sample();
    check("irq_epc", O_epc, 16'h0012);
    check("irq_not_halted", O_halted, 1'b0);
    check("irq_addr", O_mem_addr, 16'h0004);
    drive();
    do_fetch(16'h9002);
    drive();
    I_ir_ack = 1'b1;
    I_halt   = 1'b1;
    drive();
    I_ir_ack = 1'b0;
    I_halt   = 1'b0;
    sample();
    check("irq_pre_halt", O_halted, 1'b1);
    drive();
    I_irq = 1'b1;
    sample();
    check("irq_wake_ack", O_irq_ack, 1'b1);
    drive();
    I_irq = 1'b0;
    sample();
    check("irq_woke", O_halted, 1'b0);
    check("irq_wake_addr", O_mem_addr, 16'h0004);
    for (int c = 0; c < 4; c++) drive();
    sample();
    check("irq_err_halt", O_fetch_err, 1'b1);
    drive();
    I_irq = 1'b1;
    sample();
    check("irq_err_ack", O_irq_ack, 1'b0);
    check("irq_err_pc_en", O_pc_enable, 1'b0);
    drive();
    I_irq = 1'b0;
    sample();
    check("irq_err_halted", O_halted, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller that sequences the 16-bit program counter. It issues instruction-memory reads at the current PC, captures the returned word into an instruction register, and hands it to the decoder with a valid/ack handshake. It is the only driver of the PC's enable, write and load-value inputs: it increments the PC on each accepted fetch, loads it on branch redirect, and halts on command or on a fetch timeout.

Parameters:
MEM_TIMEOUT, 16, max cycles S_FETCH waits for I_mem_ready before flagging an error; 0 disables the timeout
IRQ_VECTOR, 16'h0004, PC load value on interrupt entry (only with FETCH_IRQ_EN)

Ports:
I_clk  in  1  clock
I_reset  in  1  synchronous, active-high reset
I_pc  in  16  current PC value (PC register output)
O_pc_enable  out  1  PC enable; one-cycle pulse
O_pc_write  out  1  PC load select (1 = load O_pc_in, 0 = +2)
O_pc_in  out  16  PC load value
O_mem_req  out  1  instruction read request
O_mem_addr  out  16  read address
I_mem_ready  in  1  read data valid this cycle
I_mem_data  in  16  read data
O_ir  out  16  instruction register
O_ir_valid  out  1  O_ir holds an unconsumed instruction
I_ir_ack  in  1  decoder consumes O_ir
I_branch_valid  in  1  redirect request, sampled only with I_ir_ack
I_branch_target  in  16  redirect address
I_halt  in  1  halt request, sampled only with I_ir_ack
O_halted  out  1  high in S_HALT
O_fetch_err  out  1  sticky timeout flag

Behaviour:
- Reset is I_reset, synchronous, active-high, on clock I_clk. It overrides everything: state becomes S_FETCH; O_ir=0; O_ir_valid=0; O_fetch_err=0; timeout counter=0; all pulse outputs are 0. The PC itself is reset by the same I_reset.
- States: S_FETCH, S_ISSUE, S_HALT.
- O_mem_addr = I_pc (combinational). O_mem_req = 1 only in S_FETCH.
- S_FETCH:
  - While I_mem_ready=0, the counter increments.
  - When I_mem_ready=1: O_ir <= I_mem_data; O_ir_valid <= 1; O_pc_enable=1 and O_pc_write=0 (PC+2 at the next edge); counter clears; next state S_ISSUE.
  - If MEM_TIMEOUT!=0 and the counter reaches MEM_TIMEOUT-1 with I_mem_ready=0: O_fetch_err <= 1; next state S_HALT. I_mem_ready=1 on that same cycle wins, with a normal capture and no error.
- S_ISSUE: O_ir_valid=1 and O_ir is stable until ack. On I_ir_ack=1:
  - O_ir_valid <= 0.
  - If I_branch_valid=1: O_pc_enable=1, O_pc_write=1, O_pc_in={I_branch_target[15:1],1'b0} (bit 0 forced to 0).
  - If I_halt=1: next state S_HALT. A branch on the same cycle still loads the PC.
  - Otherwise: next state S_FETCH.
  - Without ack, the state holds. I_branch_valid and I_halt are ignored while I_ir_ack=0.
- During S_ISSUE, I_pc = fetched address + 2. The decoder computes relative targets from that value.
- S_HALT: O_halted=1, no memory requests, no PC activity. Only reset exits (or an interrupt, see below). An error halt never exits except by reset.
- Latency: from the I_mem_ready cycle, O_ir_valid is high on the next cycle. The minimum loop is 2 cycles per instruction (1 fetch cycle + 1 issue cycle with ack).
- When O_pc_write=0, O_pc_in=0.
- The PC wraps naturally: 16'hFFFE+2 = 16'h0000.

Optional Feature:
FETCH_IRQ_EN.
- Defined: adds ports I_irq (in, 1), O_irq_ack (out, 1, pulse) and O_epc (out, 16, reset 0).
- An interrupt is taken on an S_ISSUE ack cycle or any cycle in S_HALT with O_fetch_err=0, when I_irq=1:
  - O_epc <= return address: masked branch target if branch, else I_pc.
  - O_pc_enable=1, O_pc_write=1, O_pc_in=IRQ_VECTOR; O_irq_ack=1; next state S_FETCH.
  - The interrupt overrides the branch load and I_halt on the same ack. O_epc keeps the branch target.
- Undefined: ports absent; I_irq behaviour does not exist; identical to the base behaviour.

Test Plan:
- Reset then mem ready on every request with data 16'h1111, 16'h2222, ack immediately -> addresses 0,2,4; O_ir sequence 1111, 2222; one O_pc_enable pulse per fetch, O_pc_write=0.
- Ack with I_branch_valid=1, target 16'h0101 -> O_pc_write pulse, O_pc_in=16'h0100, next O_mem_addr=16'h0100.
- I_mem_ready held 0, MEM_TIMEOUT=4 -> after 4 S_FETCH cycles O_fetch_err=1, O_halted=1, O_mem_req=0; ready=1 on cycle 4 instead -> normal capture, no error.
- Decoder withholds ack 5 cycles with I_branch_valid=1 and no ack -> O_ir stable, no PC activity, branch ignored; ack then proceeds.
- Ack with I_halt=1 -> O_halted=1 until I_reset; reset mid-S_ISSUE -> O_ir_valid=0, fetch restarts at address 0.
- FETCH_IRQ_EN: I_irq on ack at I_pc=16'h0012 -> O_epc=16'h0012, next fetch at 16'h0004; I_irq during a halt -> wakes; during an error halt -> ignored.
